// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types and helpers for the time-multiplexed IIR engine
package iir_pkg;

  typedef enum logic {LPF = 1'b0, HPF = 1'b1} filt_mode_e;

  typedef enum logic [2:0] {IDLE, LOAD, DIFF, MUL, WB, OUT} state_e;

  // Offset between offset-binary samples and their signed value.
  function automatic int half_scale(input int n);
    return 1 << (n - 1);
  endfunction

  function automatic logic [31:0] sat_u(input logic signed [31:0] value, input int n);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< n) - 32'sd1;
    if (value < 0) return '0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/iir_round_mul.sv
// rtl/iir_round_mul.sv - signed d times unsigned alpha, round-half-up, >>> CW, registered
module iir_round_mul #(
  parameter int DW = 13,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic signed [DW-1:0] d,
  input  logic [CW-1:0]        coef,
  output logic signed [DW-1:0] p
);

  localparam int PW = DW + CW + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (CW - 1);

  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] p_next;

  // |alpha| < 1, so the shifted product always fits back into DW bits.
  always_comb begin
    prod   = PW'(d) * $signed(PW'({1'b0, coef}));
    p_next = DW'((prod + HALF) >>> CW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else if (en) begin
      p <= p_next;
    end
  end

endmodule

// File: rtl/iir_mux_filter.sv
// rtl/iir_mux_filter.sv - NCH-channel first-order LPF/HPF sharing one multiplier
// Optional IIR_SAT_FLAG_EN adds sticky sat_flag and clr_sat.
module iir_mux_filter
  import iir_pkg::*;
#(
  parameter int N   = 10,
  parameter int NCH = 2,
  parameter int CW  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*N-1:0]   in_data,
  input  logic [NCH*CW-1:0]  coef,
  input  logic [NCH-1:0]     mode,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*N-1:0]   out_data
`ifdef IIR_SAT_FLAG_EN
  ,
  output logic [NCH-1:0]     sat_flag,
  input  logic               clr_sat
`endif
);

  localparam int W   = N + 2;
  localparam int DW  = W + 1;
  localparam int SW  = W + 2;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OFS = half_scale(N);
  localparam logic signed [SW-1:0] Y_HI = SW'((1 << (W - 1)) - 1);
  localparam logic signed [SW-1:0] Y_LO = SW'(-(1 << (W - 1)));

  state_e               state;
  logic [CHW-1:0]       ch;
  logic [NCH*N-1:0]     in_lat;
  logic [NCH*CW-1:0]    coef_lat;
  logic [NCH-1:0]       mode_lat;
  logic signed [W-1:0]  x_all  [NCH];
  logic signed [W-1:0]  y_prev [NCH];
  logic signed [W-1:0]  x_prev [NCH];
  logic signed [DW-1:0] d_reg;
  logic signed [DW-1:0] d_next;
  logic signed [DW-1:0] p;
  logic signed [SW-1:0] y_sum;
  logic signed [W-1:0]  y_cl;
  logic signed [31:0]   o_raw;

  iir_round_mul #(.DW(DW), .CW(CW)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == MUL),
    .d       (d_reg),
    .coef    (coef_lat[ch*CW +: CW]),
    .p       (p)
  );

  always_comb begin
    if (filt_mode_e'(mode_lat[ch]) == HPF) begin
      d_next = DW'(y_prev[ch]) + DW'(x_all[ch]) - DW'(x_prev[ch]);
      y_sum  = SW'(p);
    end else begin
      d_next = DW'(x_all[ch]) - DW'(y_prev[ch]);
      y_sum  = SW'(y_prev[ch]) + SW'(p);
    end
    if (y_sum > Y_HI)      y_cl = W'(Y_HI);
    else if (y_sum < Y_LO) y_cl = W'(Y_LO);
    else                   y_cl = W'(y_sum);
    o_raw = 32'(y_cl) + OFS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      ch        <= '0;
      d_reg     <= '0;
      in_lat    <= '0;
      coef_lat  <= '0;
      mode_lat  <= '0;
      for (int i = 0; i < NCH; i++) begin
        x_all[i]  <= '0;
        y_prev[i] <= '0;
        x_prev[i] <= '0;
      end
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        y_prev[i] <= '0;
        x_prev[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_lat   <= in_data;
          coef_lat <= coef;
          mode_lat <= mode;
          ch       <= '0;
          in_ready <= 1'b0;
          state    <= LOAD;
        end
        // Offset-binary to signed conversion gets its own cycle.
        LOAD: begin
          for (int i = 0; i < NCH; i++) begin
            x_all[i] <= W'({1'b0, in_lat[i*N +: N]}) - W'(OFS);
          end
          state <= DIFF;
        end
        DIFF: begin
          d_reg <= d_next;
          state <= MUL;
        end
        MUL: state <= WB;
        WB: begin
          y_prev[ch]         <= y_cl;
          x_prev[ch]         <= x_all[ch];
          out_data[ch*N +: N] <= N'(sat_u(o_raw, N));
          if (ch == CHW'(NCH - 1)) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            ch    <= ch + CHW'(1);
            state <= DIFF;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IIR_SAT_FLAG_EN
  logic sat_hit;
  assign sat_hit = (y_sum > Y_HI) || (y_sum < Y_LO) || (sat_u(o_raw, N) != o_raw);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_flag <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!flush && state == WB && ch == CHW'(i) && sat_hit) sat_flag[i] <= 1'b1;
        else if (clr_sat)                                       sat_flag[i] <= 1'b0;
      end
    end
  end
`endif

endmodule
